// File: rtl/apb_bridge_ctrl.sv
// APB-side sequencer for the AHB2APB bridge.
// Qualifies AHB requests, decodes the slave and runs SETUP/ENABLE.
module apb_bridge_ctrl #(
    parameter logic [31:0] SLV0_BASE     = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE     = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE     = 32'h8800_0000,
    parameter int          SLV_SIZE_LOG2 = 26
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [1:0]  Htrans,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        Pwrite,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WWAIT  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ENABLE = 3'd3;
    localparam logic [2:0] ST_ERR1   = 3'd4;
    localparam logic [2:0] ST_ERR2   = 3'd5;

    localparam int RW = 32 - SLV_SIZE_LOG2;

    localparam logic [RW-1:0] REG0 = SLV0_BASE[31:SLV_SIZE_LOG2];
    localparam logic [RW-1:0] REG1 = SLV1_BASE[31:SLV_SIZE_LOG2];
    localparam logic [RW-1:0] REG2 = SLV2_BASE[31:SLV_SIZE_LOG2];

    logic [2:0]    state;
    logic [2:0]    sel_q;
    logic [2:0]    dec;
    logic [RW-1:0] region;
    logic          req;
    logic          hit;

    // Htrans[0] only separates SEQ from NONSEQ, which is irrelevant here
    logic unused_trans_lsb;
    assign unused_trans_lsb = Htrans[0];

    assign region = Haddr[31:SLV_SIZE_LOG2];
    assign req    = Hreadyin & Htrans[1];
    assign hit    = |dec;

    // Address window decode to a one-hot slave select
    always_comb begin
        dec = 3'b000;
        unique case (1'b1)
            (region == REG0): dec = 3'b001;
            (region == REG1): dec = 3'b010;
            (region == REG2): dec = 3'b100;
            default:          dec = 3'b000;
        endcase
    end

    // Protocol FSM; every output is registered and set on state entry
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state     <= ST_IDLE;
            sel_q     <= 3'b000;
            Pwrite    <= 1'b0;
            Pselx     <= 3'b000;
            Penable   <= 1'b0;
            Paddr     <= 32'd0;
            Pwdata    <= 32'd0;
            Hreadyout <= 1'b1;
            Hresp     <= 2'b00;
            Hrdata    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && hit) begin
                        Paddr     <= Haddr;
                        Pwrite    <= Hwrite;
                        sel_q     <= dec;
                        Hreadyout <= 1'b0;
                        if (Hwrite) begin
                            // select is held back until write data is latched
                            state <= ST_WWAIT;
                        end else begin
                            Pselx <= dec;
                            state <= ST_SETUP;
                        end
                    end else if (req) begin
                        Hreadyout <= 1'b0;
                        Hresp     <= 2'b01;
                        state     <= ST_ERR1;
                    end
                end
                ST_WWAIT: begin
                    Pwdata <= Hwdata;
                    Pselx  <= sel_q;
                    state  <= ST_SETUP;
                end
                ST_SETUP: begin
                    Penable <= 1'b1;
                    state   <= ST_ENABLE;
                end
                ST_ENABLE: begin
                    Penable   <= 1'b0;
                    Pselx     <= 3'b000;
                    Hreadyout <= 1'b1;
                    if (!Pwrite) begin
                        Hrdata <= Prdata;
                    end
                    state <= ST_IDLE;
                end
                ST_ERR1: begin
                    Hreadyout <= 1'b1;
                    state     <= ST_ERR2;
                end
                ST_ERR2: begin
                    Hresp <= 2'b00;
                    state <= ST_IDLE;
                end
                default: begin
                    Penable   <= 1'b0;
                    Pselx     <= 3'b000;
                    Hreadyout <= 1'b1;
                    Hresp     <= 2'b00;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Directed bench for apb_bridge_ctrl.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_apb_bridge_ctrl;

    logic        Hclk;
    logic        Hresetn;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic        Hreadyin;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        Pwrite;
    logic [2:0]  Pselx;
    logic        Penable;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;

    int n_cmp;
    int n_err;

    apb_bridge_ctrl dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Htrans    (Htrans),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Prdata    (Prdata),
        .Pwrite    (Pwrite),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // advance one cycle and settle away from the edge
    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic idle_bus();
        Htrans   = 2'b00;
        Hwrite   = 1'b0;
        Hreadyin = 1'b1;
    endtask

    task automatic test_reset();
        Hresetn  = 1'b0;
        Htrans   = 2'b10;
        Hwrite   = 1'b0;
        Hreadyin = 1'b1;
        Haddr    = 32'h8000_0000;
        Hwdata   = 32'd0;
        Prdata   = 32'd0;
        tick();
        tick();
        n_cmp++; if (Hreadyout !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", Hreadyout); end
        n_cmp++; if (Hresp !== 2'b00) begin n_err++; $display("FAIL rst_resp: got %b want 00", Hresp); end
        n_cmp++; if (Pselx !== 3'b000) begin n_err++; $display("FAIL rst_sel: got %b want 000", Pselx); end
        n_cmp++; if (Penable !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b want 0", Penable); end
        n_cmp++; if (Paddr !== 32'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", Paddr); end
        n_cmp++; if (Hrdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", Hrdata); end
        n_cmp++; if (Pwrite !== 1'b0) begin n_err++; $display("FAIL rst_pwrite: got %b want 0", Pwrite); end
        idle_bus();
        Hresetn = 1'b1;
        tick();
        n_cmp++; if (Hreadyout !== 1'b1 || Pselx !== 3'b000) begin n_err++; $display("FAIL rst_idle: got rdy=%b sel=%b want 1/000", Hreadyout, Pselx); end
    endtask

    task automatic test_read();
        Htrans = 2'b10;
        Hwrite = 1'b0;
        Haddr  = 32'h8000_0010;
        Prdata = 32'd25;
        tick();
        idle_bus();
        n_cmp++; if (Pselx !== 3'b001) begin n_err++; $display("FAIL rd_c1_sel: got %b want 001", Pselx); end
        n_cmp++; if (Penable !== 1'b0) begin n_err++; $display("FAIL rd_c1_en: got %b want 0", Penable); end
        n_cmp++; if (Hreadyout !== 1'b0) begin n_err++; $display("FAIL rd_c1_rdy: got %b want 0", Hreadyout); end
        n_cmp++; if (Paddr !== 32'h8000_0010) begin n_err++; $display("FAIL rd_c1_addr: got %h want 80000010", Paddr); end
        tick();
        n_cmp++; if (Penable !== 1'b1) begin n_err++; $display("FAIL rd_c2_en: got %b want 1", Penable); end
        n_cmp++; if (Pselx !== 3'b001) begin n_err++; $display("FAIL rd_c2_sel: got %b want 001", Pselx); end
        n_cmp++; if (Hreadyout !== 1'b0) begin n_err++; $display("FAIL rd_c2_rdy: got %b want 0", Hreadyout); end
        tick();
        n_cmp++; if (Hrdata !== 32'd25) begin n_err++; $display("FAIL rd_c3_data: got %h want 19", Hrdata); end
        n_cmp++; if (Hreadyout !== 1'b1) begin n_err++; $display("FAIL rd_c3_rdy: got %b want 1", Hreadyout); end
        n_cmp++; if (Pselx !== 3'b000 || Penable !== 1'b0) begin n_err++; $display("FAIL rd_c3_apb: got sel=%b en=%b want 000/0", Pselx, Penable); end
        n_cmp++; if (Hresp !== 2'b00) begin n_err++; $display("FAIL rd_c3_resp: got %b want 00", Hresp); end
    endtask

    task automatic test_write();
        Htrans = 2'b10;
        Hwrite = 1'b1;
        Haddr  = 32'h8400_0004;
        tick();
        idle_bus();
        Hwdata = 32'hDEAD_BEEF;
        n_cmp++; if (Hreadyout !== 1'b0) begin n_err++; $display("FAIL wr_c1_rdy: got %b want 0", Hreadyout); end
        n_cmp++; if (Pselx !== 3'b000) begin n_err++; $display("FAIL wr_c1_sel: got %b want 000", Pselx); end
        n_cmp++; if (Pwrite !== 1'b1) begin n_err++; $display("FAIL wr_c1_pwrite: got %b want 1", Pwrite); end
        tick();
        Hwdata = 32'h0000_0000;
        n_cmp++; if (Pselx !== 3'b010) begin n_err++; $display("FAIL wr_c2_sel: got %b want 010", Pselx); end
        n_cmp++; if (Penable !== 1'b0) begin n_err++; $display("FAIL wr_c2_en: got %b want 0", Penable); end
        n_cmp++; if (Pwdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_c2_wdata: got %h want deadbeef", Pwdata); end
        n_cmp++; if (Paddr !== 32'h8400_0004) begin n_err++; $display("FAIL wr_c2_addr: got %h want 84000004", Paddr); end
        tick();
        n_cmp++; if (Penable !== 1'b1 || Pselx !== 3'b010) begin n_err++; $display("FAIL wr_c3_apb: got en=%b sel=%b want 1/010", Penable, Pselx); end
        n_cmp++; if (Pwdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_c3_wdata: got %h want deadbeef", Pwdata); end
        n_cmp++; if (Pwrite !== 1'b1 || Hreadyout !== 1'b0) begin n_err++; $display("FAIL wr_c3_ctl: got pw=%b rdy=%b want 1/0", Pwrite, Hreadyout); end
        tick();
        n_cmp++; if (Hreadyout !== 1'b1) begin n_err++; $display("FAIL wr_c4_rdy: got %b want 1", Hreadyout); end
        n_cmp++; if (Hrdata !== 32'd25) begin n_err++; $display("FAIL wr_c4_hold: got %h want 19", Hrdata); end
        n_cmp++; if (Pwdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_c4_keep: got %h want deadbeef", Pwdata); end
    endtask

    task automatic test_back_to_back();
        Htrans = 2'b10;
        Hwrite = 1'b1;
        Haddr  = 32'h8800_0000;
        tick();
        idle_bus();
        Hwdata = 32'h1234_5678;
        tick();
        n_cmp++; if (Pselx !== 3'b100) begin n_err++; $display("FAIL b2b_wsel: got %b want 100", Pselx); end
        tick();
        n_cmp++; if (Pwdata !== 32'h1234_5678 || Penable !== 1'b1) begin n_err++; $display("FAIL b2b_wen: got wd=%h en=%b want 12345678/1", Pwdata, Penable); end
        tick();
        n_cmp++; if (Hreadyout !== 1'b1) begin n_err++; $display("FAIL b2b_rdy: got %b want 1", Hreadyout); end
        Htrans = 2'b10;
        Hwrite = 1'b0;
        Haddr  = 32'h8800_0008;
        Prdata = 32'h0000_CAFE;
        tick();
        idle_bus();
        n_cmp++; if (Pselx !== 3'b100 || Penable !== 1'b0) begin n_err++; $display("FAIL b2b_rsetup: got sel=%b en=%b want 100/0", Pselx, Penable); end
        n_cmp++; if (Pwrite !== 1'b0 || Paddr !== 32'h8800_0008) begin n_err++; $display("FAIL b2b_raddr: got pw=%b a=%h want 0/88000008", Pwrite, Paddr); end
        tick();
        n_cmp++; if (Penable !== 1'b1) begin n_err++; $display("FAIL b2b_ren: got %b want 1", Penable); end
        tick();
        n_cmp++; if (Hrdata !== 32'h0000_CAFE || Hreadyout !== 1'b1) begin n_err++; $display("FAIL b2b_rdata: got d=%h rdy=%b want cafe/1", Hrdata, Hreadyout); end
    endtask

    task automatic test_error();
        Htrans = 2'b10;
        Hwrite = 1'b0;
        Haddr  = 32'h9000_0000;
        tick();
        idle_bus();
        n_cmp++; if (Hresp !== 2'b01 || Hreadyout !== 1'b0) begin n_err++; $display("FAIL err_c1: got resp=%b rdy=%b want 01/0", Hresp, Hreadyout); end
        n_cmp++; if (Pselx !== 3'b000 || Penable !== 1'b0) begin n_err++; $display("FAIL err_c1_apb: got sel=%b en=%b want 000/0", Pselx, Penable); end
        tick();
        n_cmp++; if (Hresp !== 2'b01 || Hreadyout !== 1'b1) begin n_err++; $display("FAIL err_c2: got resp=%b rdy=%b want 01/1", Hresp, Hreadyout); end
        n_cmp++; if (Pselx !== 3'b000) begin n_err++; $display("FAIL err_c2_sel: got %b want 000", Pselx); end
        tick();
        n_cmp++; if (Hresp !== 2'b00 || Hreadyout !== 1'b1) begin n_err++; $display("FAIL err_c3: got resp=%b rdy=%b want 00/1", Hresp, Hreadyout); end
    endtask

    task automatic test_filter();
        Htrans = 2'b01;
        Hwrite = 1'b0;
        Haddr  = 32'h8000_0020;
        tick();
        n_cmp++; if (Pselx !== 3'b000 || Hreadyout !== 1'b1) begin n_err++; $display("FAIL flt_busy: got sel=%b rdy=%b want 000/1", Pselx, Hreadyout); end
        Htrans   = 2'b10;
        Hreadyin = 1'b0;
        tick();
        n_cmp++; if (Pselx !== 3'b000 || Hreadyout !== 1'b1) begin n_err++; $display("FAIL flt_nrdy: got sel=%b rdy=%b want 000/1", Pselx, Hreadyout); end
        Htrans   = 2'b11;
        Hreadyin = 1'b1;
        Prdata   = 32'h0000_00A5;
        tick();
        idle_bus();
        n_cmp++; if (Pselx !== 3'b001 || Paddr !== 32'h8000_0020) begin n_err++; $display("FAIL flt_seq: got sel=%b a=%h want 001/80000020", Pselx, Paddr); end
        tick();
        tick();
        n_cmp++; if (Hrdata !== 32'h0000_00A5) begin n_err++; $display("FAIL flt_seq_data: got %h want a5", Hrdata); end
    endtask

    task automatic test_reset_mid();
        Htrans = 2'b10;
        Hwrite = 1'b0;
        Haddr  = 32'h8400_0000;
        Prdata = 32'h5555_AAAA;
        tick();
        idle_bus();
        tick();
        n_cmp++; if (Penable !== 1'b1) begin n_err++; $display("FAIL rmid_en: got %b want 1", Penable); end
        Hresetn = 1'b0;
        tick();
        n_cmp++; if (Penable !== 1'b0 || Pselx !== 3'b000) begin n_err++; $display("FAIL rmid_apb: got en=%b sel=%b want 0/000", Penable, Pselx); end
        n_cmp++; if (Hreadyout !== 1'b1 || Hrdata !== 32'd0) begin n_err++; $display("FAIL rmid_ahb: got rdy=%b d=%h want 1/0", Hreadyout, Hrdata); end
        Hresetn = 1'b1;
        tick();
        n_cmp++; if (Pselx !== 3'b000 || Hreadyout !== 1'b1) begin n_err++; $display("FAIL rmid_idle: got sel=%b rdy=%b want 000/1", Pselx, Hreadyout); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        #1;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_error();
        test_filter();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
